// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter sharing one 2:1 bit mux between two requesters.
// The hold counter bounds a grant while the other side waits.
module mux_share_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CW       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] done,
    input  logic       x,
    input  logic       y,
    output logic [1:0] gnt,
    output logic       s,
    output logic       m,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          timeout_q, timeout_d;
    logic [1:0]    gnt_q;
    logic          s_q, busy_q;

    logic own, req_own, req_oth, done_own, at_lim;
    logic rel_a, rel_b, rel_c;

    assign own      = (state_q == G1);
    assign req_own  = own ? req[1] : req[0];
    assign req_oth  = own ? req[0] : req[1];
    assign done_own = own ? done[1] : done[0];
    assign at_lim   = (cnt_q == HOLD_LIM);
    assign rel_a    = done_own;
    assign rel_b    = ~req_own;
    assign rel_c    = at_lim & req_oth;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req[0] && (!req[1] || last_q)) begin
                    state_d = G0;
                    cnt_d   = '0;
                end else if (req[1]) begin
                    state_d = G1;
                    cnt_d   = '0;
                end
            end
            G0, G1: begin
                if (rel_a || rel_b || rel_c) begin
                    // timeout only when the counter is the sole reason to let go
                    timeout_d = rel_c & ~rel_a & ~rel_b;
                    last_d    = own;
                    cnt_d     = '0;
                    if (req_oth) state_d = own ? G0 : G1;
                    else         state_d = IDLE;
                end else if (!at_lim) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they move on the same edge as state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            timeout_q <= 1'b0;
            gnt_q     <= 2'b00;
            s_q       <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
            gnt_q     <= {state_d == G1, state_d == G0};
            s_q       <= (state_d == G1);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign gnt     = gnt_q;
    assign s       = s_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    assign m       = busy_q & (s_q ? y : x);

endmodule
